// File: rtl/dot_accum.sv
// Streaming dot-product accumulator: sums LEN unsigned products per vector and
// presents the total with a sticky overflow flag through a ready/valid output.
module dot_accum #(
  parameter int PROD_WIDTH = 17,
  parameter int ACC_WIDTH  = 20,
  parameter int LEN        = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [PROD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic                 r_out_ovf;
  logic                 r_out_valid;

  logic                 w_last;
  logic                 w_accept;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_last = (r_cnt == CNT_LAST);

  // Stall only the final beat while an unconsumed result is still held.
  assign in_ready = ~flush & ~(w_last & r_out_valid & ~out_ready);
  assign w_accept = in_valid & in_ready;

  assign w_sum = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, in_data};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_ovf_acc   <= 1'b0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (flush) begin
        r_acc     <= '0;
        r_ovf_acc <= 1'b0;
        r_cnt     <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          // A new result may load on the same edge the previous one is consumed.
          r_out_data  <= w_sum[ACC_WIDTH-1:0];
          r_out_ovf   <= r_ovf_acc | w_sum[ACC_WIDTH];
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_ovf_acc   <= 1'b0;
          r_cnt       <= '0;
        end else begin
          r_acc     <= w_sum[ACC_WIDTH-1:0];
          r_ovf_acc <= r_ovf_acc | w_sum[ACC_WIDTH];
          r_cnt     <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_valid = r_out_valid;

endmodule
